spi_reg_bank: RTL and testbench

//   SPI (mode 0) target and configuration register file. Sits directly upstream
//   of the PWM/output stage and drives its five 8-bit control registers.

---
 rtl/spi_reg_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 38 +++
 rtl/spi_reg_bank.sv | 190 +++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI configuration register bank.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned NUM_REGS   = 5;
  localparam int unsigned IDX_W      = $clog2(NUM_REGS);

  localparam int unsigned ADDR_EN_OUT_LO  = 0;
  localparam int unsigned ADDR_EN_OUT_HI  = 1;
  localparam int unsigned ADDR_EN_PWM_LO  = 2;
  localparam int unsigned ADDR_EN_PWM_HI  = 3;
  localparam int unsigned ADDR_PWM_DUTY   = 4;
  localparam int unsigned ADDR_ERR_CNT    = 5;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    COMMIT    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an async pin, plus edge detection on the synced level.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the pin into the chain; keep one extra flop of history for edges.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history flops reset to the pin's idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target: decodes 16-bit write frames into five control registers,
// supports readback on CIPO and counts malformed frames.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ERR_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_in,
  input  logic              copi_in,
  input  logic              ncs_in,
  output logic              cipo_out,
  output logic              cipo_oe,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe
);

  localparam int unsigned FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam int unsigned HDR_BITS = 1 + ADDR_W;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned FLUSH_W  = $clog2(SYNC_STAGES + 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;
  logic ncs_lvl, ncs_rise, ncs_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_in(sclk_in),
    .level(sclk_lvl_unused), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_in(copi_in),
    .level(copi_lvl), .rise_c(copi_rise_unused), .fall_c(copi_fall_unused)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_in(ncs_in),
    .level(ncs_lvl), .rise_c(ncs_rise), .fall_c(ncs_fall)
  );

  state_e                             state_q, state_d;
  logic [FRAME_W-1:0]                 shift_q, shift_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [FLUSH_W-1:0]                 flush_q, flush_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [ERR_W-1:0]                   err_q, err_d;
  logic [DATA_W-1:0]                  tx_q, tx_d;
  logic                               cipo_q, cipo_d;
  logic                               cipo_oe_q, cipo_oe_d;
  logic                               strobe_q, strobe_d;

  logic [ADDR_W:0]   hdr_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [DATA_W-1:0] rd_val_c;
  logic              frame_rw_c;
  logic [ADDR_W-1:0] frame_addr_c;
  logic [DATA_W-1:0] frame_data_c;

  // Header as it will look once the current rising edge is shifted in.
  assign hdr_c        = {shift_q[ADDR_W-1:0], copi_lvl};
  assign rd_addr_c    = hdr_c[ADDR_W-1:0];
  assign frame_rw_c   = shift_q[FRAME_W-1];
  assign frame_addr_c = shift_q[FRAME_W-2 -: ADDR_W];
  assign frame_data_c = shift_q[DATA_W-1:0];

  // Readback mux: register file, error counter, or zero for unmapped addresses.
  always_comb begin
    rd_val_c = '0;
    if (rd_addr_c < ADDR_W'(NUM_REGS)) begin
      rd_val_c = regs_q[rd_addr_c[IDX_W-1:0]];
    end else if (rd_addr_c == ADDR_W'(ADDR_ERR_CNT)) begin
      rd_val_c = DATA_W'(err_q);
    end
  end

  // Frame FSM: next state, shifter, bit counter, readback and commit.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    flush_d  = flush_q;
    regs_d   = regs_q;
    err_d    = err_q;
    tx_d     = tx_q;
    cipo_d   = cipo_q;
    strobe_d = 1'b0;

    unique case (state_q)
      WAIT_IDLE: begin
        // Let the synchronisers fill with real pin values before trusting ncs.
        if (flush_q != FLUSH_W'(SYNC_STAGES)) begin
          flush_d = flush_q + FLUSH_W'(1);
        end else if (ncs_lvl) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
          tx_d    = '0;
          cipo_d  = 1'b0;
        end
      end
      SHIFT: begin
        // ncs rising takes priority over any sclk edge in the same cycle.
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], copi_lvl};
          if (cnt_q != CNT_W'(FRAME_BITS + 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (cnt_q == CNT_W'(HDR_BITS - 1) && !hdr_c[ADDR_W]) begin
            tx_d = rd_val_c;
          end
        end else if (sclk_fall) begin
          cipo_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          if (frame_rw_c) begin
            if (frame_addr_c < ADDR_W'(NUM_REGS)) begin
              regs_d[frame_addr_c[IDX_W-1:0]] = frame_data_c;
              strobe_d = 1'b1;
            end else if (frame_addr_c == ADDR_W'(ADDR_ERR_CNT)) begin
              err_d = '0;
            end
          end
        end else if (err_q != {ERR_W{1'b1}}) begin
          err_d = err_q + ERR_W'(1);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    cipo_oe_d = (state_d == SHIFT) && (cnt_d >= CNT_W'(HDR_BITS)) &&
                (cnt_d < CNT_W'(FRAME_BITS));
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      flush_q   <= '0;
      regs_q    <= '0;
      err_q     <= '0;
      tx_q      <= '0;
      cipo_q    <= 1'b0;
      cipo_oe_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      regs_q    <= regs_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
      cipo_q    <= cipo_d;
      cipo_oe_q <= cipo_oe_d;
      strobe_q  <= strobe_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[IDX_W'(ADDR_EN_OUT_LO)];
  assign en_reg_out_15_8 = regs_q[IDX_W'(ADDR_EN_OUT_HI)];
  assign en_reg_pwm_7_0  = regs_q[IDX_W'(ADDR_EN_PWM_LO)];
  assign en_reg_pwm_15_8 = regs_q[IDX_W'(ADDR_EN_PWM_HI)];
  assign pwm_duty_cycle  = regs_q[IDX_W'(ADDR_PWM_DUTY)];
  assign cipo_out        = cipo_q;
  assign cipo_oe         = cipo_oe_q;
  assign wr_strobe       = strobe_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed scenarios plus random frames against a
// frame-level register/error-counter model.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk_in = 1'b0;
  logic       copi_in = 1'b0;
  logic       ncs_in = 1'b1;
  logic       cipo_out, cipo_oe, wr_strobe;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  always #5 clk = ~clk;

  spi_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .sclk_in(sclk_in), .copi_in(copi_in), .ncs_in(ncs_in),
    .cipo_out(cipo_out), .cipo_oe(cipo_oe),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] m_regs [5];
  int         m_err;
  bit         chk_en = 1'b0;
  logic [7:0] last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  function automatic logic [39:0] model_regs();
    return {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4]};
  endfunction

  function automatic logic [7:0] m_read(input int addr);
    if (addr < 5) return m_regs[addr];
    if (addr == 5) return 8'(m_err);
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_err = 0;
  endtask

  task automatic waitc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Clock bits out with SCLK = clk/8, no checking (used around resets).
  task automatic shift_raw(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      copi_in = bits[5'(n - 1 - i)];
      waitc(4);
      sclk_in = 1'b1;
      waitc(4);
      sclk_in = 1'b0;
    end
  endtask

  // One complete frame of n bits; checks CIPO/OE per bit and the commit result.
  task automatic send_frame(input logic [31:0] bits, input int n);
    bit          is_rd;
    int          addr;
    logic [7:0]  rv;
    logic [15:0] f;
    int          sc;
    int          first;
    bit          exp_st;
    is_rd = 1'b0;
    addr  = 0;
    if (n >= 9) begin
      is_rd = (bits[5'(n - 1)] == 1'b0);
      addr  = int'(bits[5'(n - 2) -: 7]);
    end
    rv = m_read(addr);
    last_rd = 8'h00;
    ncs_in = 1'b0;
    waitc(4);
    for (int i = 0; i < n; i++) begin
      copi_in = bits[5'(n - 1 - i)];
      waitc(4);
      check("cipo_oe_window", 64'(cipo_oe), 64'(i >= 8 && i <= 15));
      if (i >= 8 && i <= 15) begin
        last_rd[3'(15 - i)] = cipo_out;
        if (is_rd) check("cipo_bit", 64'(cipo_out), 64'(rv[3'(15 - i)]));
      end
      sclk_in = 1'b1;
      waitc(4);
      sclk_in = 1'b0;
    end
    waitc(4);
    chk_en = 1'b0;
    ncs_in = 1'b1;
    copi_in = 1'b0;
    sc = 0;
    first = 0;
    for (int k = 1; k <= 8; k++) begin
      waitc(1);
      if (wr_strobe === 1'b1) begin
        sc++;
        if (first == 0) first = k;
      end
    end
    exp_st = 1'b0;
    if (n == 16) begin
      f = bits[15:0];
      if (f[15]) begin
        if (f[14:8] < 7'd5) begin
          m_regs[f[10:8]] = f[7:0];
          exp_st = 1'b1;
        end else if (f[14:8] == 7'd5) begin
          m_err = 0;
        end
      end
    end else if (m_err < 15) begin
      m_err++;
    end
    check("strobe_count", 64'(sc), 64'(exp_st));
    if (exp_st) check("strobe_within_4clk", 64'(first >= 1 && first <= 4), 64'd1);
    chk_en = 1'b1;
  endtask

  // Outside commit windows: registers match the model, no strobe, no CIPO drive when deselected.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("regs", 64'(dut_regs()), 64'(model_regs()));
      check("wr_strobe_quiet", 64'(wr_strobe), 64'd0);
      if (ncs_in) check("cipo_oe_idle", 64'(cipo_oe), 64'd0);
    end
  end

  initial begin
    logic [31:0] bits;
    logic [6:0]  addr;
    int          n;
    model_reset();

    // 1. Reset values, then idle pins.
    waitc(3);
    check("rst_regs", 64'(dut_regs()), 64'd0);
    check("rst_cipo_oe_strobe", 64'({cipo_out, cipo_oe, wr_strobe}), 64'd0);
    rst_n = 1'b1;
    waitc(10);
    chk_en = 1'b1;
    waitc(20);

    // 2. Write duty cycle.
    send_frame(32'h8480, 16);
    check("t2_pwm_duty", 64'(pwm_duty_cycle), 64'h80);

    // 3. Write to unmapped address: nothing changes, no error.
    send_frame(32'h90FF, 16);
    send_frame(32'h0500, 16);
    check("t3_err_cnt", 64'(last_rd), 64'h00);

    // 4. Short and long frames count errors; write to 0x05 clears.
    send_frame(32'h0ABC, 12);
    send_frame(32'hF1234, 20);
    send_frame(32'h0500, 16);
    check("t4_err_cnt_2", 64'(last_rd), 64'h02);
    check("t4_regs", 64'(dut_regs()), 64'h00_00_00_00_80);
    send_frame(32'h8500, 16);
    send_frame(32'h0500, 16);
    check("t4_err_cnt_0", 64'(last_rd), 64'h00);

    // 5. Readback of a written register.
    send_frame(32'h82A5, 16);
    send_frame(32'h0200, 16);
    check("t5_readback", 64'(last_rd), 64'hA5);

    // 6. Reset in mid-frame; the tail of that frame is ignored.
    chk_en = 1'b0;
    ncs_in = 1'b0;
    waitc(4);
    shift_raw(32'h2A, 6);
    rst_n = 1'b0;
    model_reset();
    waitc(2);
    check("t6_rst_regs", 64'(dut_regs()), 64'd0);
    check("t6_rst_oe_strobe", 64'({cipo_out, cipo_oe, wr_strobe}), 64'd0);
    rst_n = 1'b1;
    shift_raw(32'h155, 10);
    waitc(4);
    ncs_in = 1'b1;
    waitc(12);
    chk_en = 1'b1;
    send_frame(32'h0500, 16);
    check("t6_err_cnt", 64'(last_rd), 64'h00);
    send_frame(32'h8133, 16);
    check("t6_en_out_hi", 64'(en_reg_out_15_8), 64'h33);

    // Error counter saturates at 15.
    repeat (17) send_frame(32'h1, 3);
    send_frame(32'h0500, 16);
    check("err_cnt_saturated", 64'(last_rd), 64'h0F);
    send_frame(32'h8500, 16);

    // Random frames against the model.
    repeat (60) begin
      if ($urandom_range(0, 9) < 7) begin
        n = 16;
        addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
        bits = {16'h0, 1'($urandom_range(0, 1)), addr, 8'($urandom)};
      end else begin
        n = $urandom_range(0, 20);
        bits = $urandom;
      end
      send_frame(bits, n);
    end
    send_frame(32'h0500, 16);
    check("final_err_cnt", 64'(last_rd), 64'(8'(m_err)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
